// File: rtl/alu_cmd_arbiter_if.sv
// Bundled requester, response, ALU and status signals for the two-port ALU command arbiter.
// The arbiter connects through the slave modport; the requesters and ALU connect through master.
interface alu_cmd_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_cmd;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_cmd;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [8:0]  rsp0_result;
  logic        rsp0_err;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [8:0]  rsp1_result;
  logic        rsp1_err;
  logic        alu_cmd_valid;
  logic        alu_cmd_ready;
  logic [31:0] alu_cmd;
  logic        alu_res_valid;
  logic [8:0]  alu_res;
  logic        busy;

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd,
    input  rsp0_ready, rsp1_ready,
    input  alu_cmd_ready, alu_res_valid, alu_res,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_err,
    output alu_cmd_valid, alu_cmd, busy
  );

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd,
    output rsp0_ready, rsp1_ready,
    output alu_cmd_ready, alu_res_valid, alu_res,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_err,
    input  alu_cmd_valid, alu_cmd, busy
  );
endinterface

// File: rtl/alu_cmd_arbiter.sv
// Two-port round-robin ALU command arbiter: grants one command at a time, issues it to the ALU,
// waits for the result or a timeout, and returns the response to the owning requester.
module alu_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_cmd_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_rr_ptr;
  logic [31:0] r_cmd_q;
  logic [8:0]  r_res_q;
  logic        r_err_q;
  logic [7:0]  r_tmo_cnt;

  logic        w_in_idle;
  logic        w_grant_any;
  logic        w_grant_idx;
  logic        w_accept;
  logic [31:0] w_cmd_sel;
  logic [3:0]  w_opcode;
  logic        w_op_ok;
  logic        w_tmo_hit;
  logic        w_rsp_ready;
  logic        w_in_resp;

  // Gated by reset_n so req_ready is low while reset is held even with valid requests.
  assign w_in_idle   = (r_state == S_IDLE) && reset_n;
  assign w_grant_any = bus.req0_valid || bus.req1_valid;
  assign w_grant_idx = r_rr_ptr ? bus.req1_valid : ~bus.req0_valid;
  assign w_accept    = w_in_idle && w_grant_any;
  assign w_cmd_sel   = w_grant_idx ? bus.req1_cmd : bus.req0_cmd;
  assign w_opcode    = w_cmd_sel[31:28];
  assign w_op_ok     = (w_opcode >= 4'd1) && (w_opcode <= 4'd9);
  assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
  assign w_rsp_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
  assign w_in_resp   = (r_state == S_RESP);

  assign bus.req0_ready = w_accept && !w_grant_idx;
  assign bus.req1_ready = w_accept &&  w_grant_idx;

  assign bus.alu_cmd_valid = (r_state == S_ISSUE);
  assign bus.alu_cmd       = bus.alu_cmd_valid ? r_cmd_q : '0;

  assign bus.rsp0_valid  = w_in_resp && !r_owner;
  assign bus.rsp0_result = bus.rsp0_valid ? r_res_q : '0;
  assign bus.rsp0_err    = bus.rsp0_valid && r_err_q;
  assign bus.rsp1_valid  = w_in_resp && r_owner;
  assign bus.rsp1_result = bus.rsp1_valid ? r_res_q : '0;
  assign bus.rsp1_err    = bus.rsp1_valid && r_err_q;

  assign bus.busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_rr_ptr  <= 1'b0;
      r_cmd_q   <= '0;
      r_res_q   <= '0;
      r_err_q   <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_q   <= w_cmd_sel;
            r_owner   <= w_grant_idx;
            r_tmo_cnt <= '0;
            if (w_op_ok) begin
              r_state <= S_ISSUE;
            end else begin
              r_err_q <= 1'b1;
              r_res_q <= '0;
              r_state <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          // Only a result completes the command, so the deadline also wins over a late accept.
          if (w_tmo_hit) begin
            r_err_q <= 1'b1;
            r_res_q <= '0;
            r_state <= S_RESP;
          end else if (bus.alu_cmd_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          if (bus.alu_res_valid) begin
            r_res_q <= bus.alu_res;
            r_err_q <= 1'b0;
            r_state <= S_RESP;
          end else if (w_tmo_hit) begin
            r_err_q <= 1'b1;
            r_res_q <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_rr_ptr <= ~r_owner;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_arbiter.sv
// Directed testbench for alu_cmd_arbiter with TIMEOUT=8 and a scripted ALU/requester environment.
module tb_alu_cmd_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_arbiter_if bus();

  alu_cmd_arbiter #(.TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] hi, input logic [3:0] k,
                                     input logic [7:0] op2, input logic [7:0] op1, input logic [5:0] lo);
    return {op, hi, k, op2, op1, lo};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0_valid    = 1'b0;
    bus.req0_cmd      = '0;
    bus.req1_valid    = 1'b0;
    bus.req1_cmd      = '0;
    bus.rsp0_ready    = 1'b0;
    bus.rsp1_ready    = 1'b0;
    bus.alu_cmd_ready = 1'b0;
    bus.alu_res_valid = 1'b0;
    bus.alu_res       = '0;
  endtask

  task automatic test_reset;
    logic [7:0] flags;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset_n = 1'b0;
    #2;
    flags = {bus.busy, bus.req0_ready, bus.req1_ready, bus.alu_cmd_valid,
             bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err};
    n_checks++;
    if (flags !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000000", flags);
    end
    n_checks++;
    if ({bus.alu_cmd, bus.rsp0_result, bus.rsp1_result} !== 50'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", bus.alu_cmd, bus.rsp0_result, bus.rsp1_result);
    end
    tick();
    tick();
    idle_inputs();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_after: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single;
    logic [31:0] cmd;
    cmd = 32'h100140C0;
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = cmd;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    n_checks++;
    if ({bus.alu_cmd_valid, bus.alu_cmd, bus.busy} !== {1'b1, cmd, 1'b1}) begin
      n_fail++; $display("FAIL single_issue: got v=%b cmd=%h busy=%b want v=1 cmd=%h busy=1",
                         bus.alu_cmd_valid, bus.alu_cmd, bus.busy, cmd);
    end
    bus.alu_cmd_ready = 1'b1;
    tick();
    bus.alu_cmd_ready = 1'b0;
    n_checks++;
    if (bus.alu_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_wait_cmd_valid: got %b want 0", bus.alu_cmd_valid);
    end
    tick();
    tick();
    bus.alu_res_valid = 1'b1;
    bus.alu_res       = 9'h008;
    n_checks++;
    if (bus.rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early_rsp: got %b want 0", bus.rsp0_valid);
    end
    tick();
    bus.alu_res_valid = 1'b0;
    n_checks++;
    if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err} !== {1'b1, 9'h008, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp0: got v=%b r=%h e=%b want v=1 r=008 e=0",
                         bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err);
    end
    n_checks++;
    if ({bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err} !== 11'h0) begin
      n_fail++; $display("FAIL single_rsp1_quiet: got v=%b r=%h e=%b want 0",
                         bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    n_checks++;
    if ({bus.rsp0_valid, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: got v=%b busy=%b want 00", bus.rsp0_valid, bus.busy);
    end
  endtask

  task automatic test_invalid_opcode;
    bus.req1_valid = 1'b1;
    bus.req1_cmd   = 32'hF0000000;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL invalid_grant: got %b want 01", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err} !== {1'b1, 9'h000, 1'b1}) begin
        n_fail++; $display("FAIL invalid_rsp1[%0d]: got v=%b r=%h e=%b want v=1 r=000 e=1",
                           c, bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err);
      end
      n_checks++;
      if ({bus.alu_cmd_valid, bus.rsp0_valid} !== 2'b00) begin
        n_fail++; $display("FAIL invalid_quiet[%0d]: got alu_v=%b rsp0_v=%b want 00",
                           c, bus.alu_cmd_valid, bus.rsp0_valid);
      end
      if (c == 0) tick();
    end
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [31:0] c0 [4];
    logic [31:0] c1 [4];
    logic [8:0]  rexp [8];
    logic [31:0] ec;
    logic [11:0] got;
    int p;
    int idx;
    c0[0] = mk(4'h1, 2'b00, 4'h0, 8'h05, 8'h03, 6'h00);
    c0[1] = mk(4'h2, 2'b01, 4'h3, 8'h10, 8'h20, 6'h01);
    c0[2] = mk(4'h3, 2'b00, 4'h0, 8'hFF, 8'h01, 6'h00);
    c0[3] = mk(4'h9, 2'b10, 4'hA, 8'h00, 8'h7F, 6'h3F);
    c1[0] = mk(4'h4, 2'b11, 4'h5, 8'h11, 8'h22, 6'h2A);
    c1[1] = mk(4'h5, 2'b11, 4'h0, 8'h80, 8'h80, 6'h2A);
    c1[2] = mk(4'h6, 2'b11, 4'hF, 8'h0F, 8'hF0, 6'h2A);
    c1[3] = mk(4'h7, 2'b11, 4'h1, 8'h33, 8'h44, 6'h2A);
    rexp = '{9'h008, 9'h101, 9'h010, 9'h1FE, 9'h0F0, 9'h055, 9'h100, 9'h0AA};
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_cmd   = c0[0];
    bus.req1_cmd   = c1[0];
    for (int k = 0; k < 8; k++) begin
      p   = k % 2;
      idx = k / 2;
      ec  = (p == 1) ? c1[idx] : c0[idx];
      #1;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== ((p == 1) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want port %0d", k, {bus.req0_ready, bus.req1_ready}, p);
      end
      tick();
      if (p == 0) begin
        if (idx < 3) bus.req0_cmd = c0[idx + 1];
        else bus.req0_valid = 1'b0;
      end else begin
        if (idx < 3) bus.req1_cmd = c1[idx + 1];
        else bus.req1_valid = 1'b0;
      end
      n_checks++;
      if ({bus.alu_cmd_valid, bus.alu_cmd} !== {1'b1, ec}) begin
        n_fail++; $display("FAIL rr_alu_cmd[%0d]: got v=%b cmd=%h want v=1 cmd=%h", k, bus.alu_cmd_valid, bus.alu_cmd, ec);
      end
      bus.alu_cmd_ready = 1'b1;
      tick();
      bus.alu_cmd_ready = 1'b0;
      bus.alu_res_valid = 1'b1;
      bus.alu_res       = rexp[k];
      tick();
      bus.alu_res_valid = 1'b0;
      got = (p == 1) ? {bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err, bus.rsp0_valid}
                     : {bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err, bus.rsp1_valid};
      n_checks++;
      if (got !== {1'b1, rexp[k], 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got %h want %h on port %0d", k, got, {1'b1, rexp[k], 1'b0, 1'b0}, p);
      end
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        n_fail++; $display("FAIL rr_ready_in_resp[%0d]: got %b want 00", k, {bus.req0_ready, bus.req1_ready});
      end
      if (p == 1) bus.rsp1_ready = 1'b1;
      else bus.rsp0_ready = 1'b1;
      tick();
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
    end
  endtask

  task automatic test_timeout;
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = 32'h100140C0;
    tick();
    bus.req0_valid    = 1'b0;
    bus.alu_cmd_ready = 1'b1;
    n_checks++;
    if (bus.alu_cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL tmo_issue: got %b want 1", bus.alu_cmd_valid);
    end
    for (int c = 1; c < 8; c++) begin
      tick();
      n_checks++;
      if ({bus.rsp0_valid, bus.alu_cmd_valid} !== 2'b00) begin
        n_fail++; $display("FAIL tmo_early[%0d]: got rsp0_v=%b alu_v=%b want 00", c, bus.rsp0_valid, bus.alu_cmd_valid);
      end
    end
    tick();
    bus.alu_cmd_ready = 1'b0;
    n_checks++;
    if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err, bus.alu_cmd_valid} !== {1'b1, 9'h000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_rsp: got v=%b r=%h e=%b alu_v=%b want v=1 r=000 e=1 alu_v=0",
                         bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err, bus.alu_cmd_valid);
    end
    bus.alu_res_valid = 1'b1;
    bus.alu_res       = 9'h0AA;
    tick();
    bus.alu_res_valid = 1'b0;
    n_checks++;
    if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err} !== {1'b1, 9'h000, 1'b1}) begin
      n_fail++; $display("FAIL tmo_late_result: got v=%b r=%h e=%b want v=1 r=000 e=1",
                         bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = mk(4'h2, 2'b00, 4'h0, 8'h12, 8'h34, 6'h00);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL bp_fallback_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.alu_cmd_ready = 1'b1;
    tick();
    bus.alu_cmd_ready = 1'b0;
    bus.alu_res_valid = 1'b1;
    bus.alu_res       = 9'h123;
    tick();
    bus.alu_res_valid = 1'b0;
    bus.req1_valid    = 1'b1;
    bus.req1_cmd      = 32'h10000000;
    for (int c = 0; c < 10; c++) begin
      bus.alu_res_valid = (c == 3);
      bus.alu_res       = (c == 3) ? 9'h1FF : 9'h000;
      #1;
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err} !== {1'b1, 9'h123, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%h e=%b want v=1 r=123 e=0",
                           c, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err);
      end
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", c, {bus.req0_ready, bus.req1_ready});
      end
      tick();
    end
    bus.alu_res_valid = 1'b0;
    bus.req0_valid    = 1'b0;
    bus.req1_valid    = 1'b0;
    n_checks++;
    if (bus.rsp0_result !== 9'h123) begin
      n_fail++; $display("FAIL bp_after_stray: got %h want 123", bus.rsp0_result);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    logic [7:0] flags;
    bus.req0_valid = 1'b1;
    bus.req0_cmd   = 32'h300140C0;
    tick();
    bus.alu_cmd_ready = 1'b1;
    tick();
    bus.alu_cmd_ready = 1'b0;
    bus.req1_valid    = 1'b1;
    bus.req1_cmd      = 32'h40000000;
    n_checks++;
    if ({bus.busy, bus.alu_cmd_valid} !== 2'b10) begin
      n_fail++; $display("FAIL rstw_in_wait: got busy=%b alu_v=%b want 10", bus.busy, bus.alu_cmd_valid);
    end
    reset_n = 1'b0;
    #1;
    flags = {bus.busy, bus.req0_ready, bus.req1_ready, bus.alu_cmd_valid,
             bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err};
    n_checks++;
    if (flags !== 8'h00) begin
      n_fail++; $display("FAIL rstw_flags: got %b want 00000000", flags);
    end
    tick();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rstw_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n_checks++;
    if ({bus.alu_cmd_valid, bus.alu_cmd} !== {1'b1, 32'h300140C0}) begin
      n_fail++; $display("FAIL rstw_reissue: got v=%b cmd=%h want v=1 cmd=300140c0", bus.alu_cmd_valid, bus.alu_cmd);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_invalid_opcode();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_arbiter.md
# alu_cmd_arbiter

Two-port command arbiter and sequencer in front of the 8-bit ALU core. It accepts 32-bit ALU command words from two independent requesters and grants them round-robin. It issues one command at a time to the ALU, waits for the 9-bit result (or a timeout), and returns the result to the requester that issued the command. It sits between the APB-facing command sources and the ALU datapath; the ALU never sees more than one outstanding command.

## Interface
- `TIMEOUT`, default 64 — maximum number of cycles spent in ISSUE+WAIT before an error response; legal range 2..255.
- `clk` in 1 — clock, rising edge.
- `reset_n` in 1 — reset, asynchronous, active-low.
- `req0_valid`/`req1_valid` in 1 — requester n presents a command.
- `req0_ready`/`req1_ready` out 1 — command accepted on `valid & ready`.
- `req0_cmd`/`req1_cmd` in 32 — command word. Fields:
  - [31:28] opcode
  - [25:22] constant
  - [21:14] op2
  - [13:6] op1
- `rsp0_valid`/`rsp1_valid` out 1 — response available for requester n.
- `rsp0_ready`/`rsp1_ready` in 1 — requester n takes the response.
- `rsp0_result`/`rsp1_result` out 9 — ALU result.
- `rsp0_err`/`rsp1_err` out 1 — 1 means bad opcode or timeout.
- `alu_cmd_valid` out 1 — command offered to the ALU.
- `alu_cmd_ready` in 1 — ALU accepts the command.
- `alu_cmd` out 32 — captured command word.
- `alu_res_valid` in 1 — one-cycle result strobe from the ALU.
- `alu_res` in 9 — ALU result.
- `busy` out 1 — high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. Encoding is free.
- **Registered state:**
  - `owner` (1 bit)
  - `rr_ptr` (1 bit, the requester preferred on a tie)
  - `cmd_q` (32 bits)
  - `res_q` (9 bits)
  - `err_q` (1 bit)
  - `tmo_cnt` (8 bits)
- **IDLE:**
  - `req_ready` is combinational. It is high only for the granted requester: requester `rr_ptr` if it is valid, otherwise the other requester if it is valid.
  - On handshake: `cmd_q <= cmd`, `owner <=` granted index, `tmo_cnt <= 0`.
  - Valid opcode (1..9): next state ISSUE.
  - Invalid opcode (0, 10..15): `err_q <= 1`, `res_q <= 0`, next state RESP. The ALU is not touched.
- **ISSUE:**
  - `alu_cmd_valid = 1` and `alu_cmd = cmd_q`, both held stable until `alu_cmd_ready`.
  - On `alu_cmd_ready`: next state WAIT.
  - `tmo_cnt` increments every cycle.
- **WAIT:**
  - `tmo_cnt` increments every cycle.
  - On `alu_res_valid`: `res_q <= alu_res`, `err_q <= 0`, next state RESP.
- **Timeout:** in ISSUE or WAIT, if `tmo_cnt == TIMEOUT-1` and no completing event occurs that cycle: `err_q <= 1`, `res_q <= 0`, next state RESP, and `alu_cmd_valid` drops.
- **RESP:**
  - `rsp<owner>_valid = 1`, with `result = res_q` and `err = err_q`.
  - The other response port stays all-zero.
  - On `rsp_ready`: `rr_ptr <= ~owner`, next state IDLE.
- **Stray results:** `alu_res_valid` outside WAIT is ignored and not stored.
- **Widths:** the result passes through unmodified (9-bit, bit 8 = carry). `alu_cmd` bits [27:26] and [5:0] pass through unchanged.
- **Reset (any time, including mid-operation):**
  - state IDLE
  - `rr_ptr`, `owner`, `tmo_cnt`, `cmd_q`, `res_q`, `err_q` all 0
  - all outputs 0, including `busy`
  - an in-flight ALU command is abandoned.

## Timing
- Command accepted at edge T. Then `alu_cmd_valid` is high in cycle T+1.
- If `alu_cmd_ready` is already high, WAIT begins at T+2.
- `alu_res_valid` in cycle R gives `rsp_valid` in cycle R+1.
- Invalid opcode: `rsp_valid` in cycle T+1, error set.
- Timeout: `rsp_valid` exactly TIMEOUT cycles after entry into ISSUE, error set.
- Back-to-back throughput: the `rsp_ready` edge returns to IDLE, so the next accept is possible one cycle later. Minimum turnaround is 4 cycles per command with a 0-cycle ALU.
- `rsp_valid` and its data are held stable until `rsp_ready`. Backpressure holds RESP indefinitely, with no timeout.
- `req_ready` is never high outside IDLE. Both `req_ready` signals are never high together.
- Simultaneous `alu_res_valid` and timeout on the same cycle: the result wins (`err = 0`).

## Test plan
- **Single command.** Reset; `req0_cmd = 0x10000000 | (0x05<<14) | (0x03<<6)` (ADD1); ALU model returns 0x008 two cycles after `alu_cmd_ready` -> `rsp0_valid` with `result = 0x008`, `err = 0`; `rsp1_valid` stays 0.
- **Round-robin.** Both requesters valid continuously with four commands each -> grants alternate 0,1,0,1,…; each response goes to the correct port with the matching result.
- **Invalid opcode.** `req1_cmd = 0xF0000000` -> `rsp1_valid` one cycle after accept, `err = 1`, `result = 0`; `alu_cmd_valid` never asserts.
- **Timeout.** `TIMEOUT = 8`; ALU model holds `alu_cmd_ready = 1` but never strobes `alu_res_valid` -> `rsp0_err = 1` exactly 8 cycles after ISSUE entry. A late `alu_res_valid` afterwards is ignored.
- **Backpressure and stray strobe.** Hold `rsp0_ready = 0` for 10 cycles -> `rsp0_valid`/`result` stay stable, `req_ready` stays 0, and a stray `alu_res_valid = 1` with `alu_res = 0x1FF` does not alter `result`.
- **Reset mid-WAIT.** Assert `reset_n = 0` for 1 cycle while in WAIT -> all outputs 0 immediately; the next command issued after reset is granted to requester 0 first.
